// File: rtl/vector_lane_serializer.sv
// Vector-to-lane serializer: buffers whole input vectors in a small FIFO and
// emits them one lane element per accepted transfer, lane 0 first.
module vector_lane_serializer #(
    parameter int unsigned bitwidth = 16,
    parameter int unsigned N        = 8,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N*bitwidth-1:0]     in,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic [bitwidth-1:0]       out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned VEC_W  = N * bitwidth;

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(N - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

    logic [VEC_W-1:0]    vec_mem [DEPTH];
    logic [DEPTH-1:0]    last_mem;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LANE_W-1:0]   lane_idx;

    logic                full;
    logic                push;
    logic                xfer;
    logic                pop;
    logic                at_last_lane;
    logic [VEC_W-1:0]    head_vec;
    logic                head_last;
    logic [bitwidth-1:0] lane_sel [N];

    // A full FIFO drops the input even when a pop frees a slot this cycle.
    assign full         = (fifo_count == FULL_COUNT);
    assign push         = in_valid && !full;
    assign out_valid    = (fifo_count != '0);
    assign xfer         = out_valid && out_ready;
    assign at_last_lane = (lane_idx == LAST_LANE);
    assign pop          = xfer && at_last_lane;

    assign head_vec  = vec_mem[rd_ptr];
    assign head_last = last_mem[rd_ptr];

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane_sel[g] = head_vec[g*bitwidth +: bitwidth];
    end

    assign out_data = lane_sel[lane_idx];
    assign out_last = head_last && at_last_lane && out_valid;

    // Vector storage; pointers are cleared by reset, so contents need no reset.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            vec_mem[wr_ptr]  <= in;
            last_mem[wr_ptr] <= in_last;
        end
    end

    // Pointers, occupancy, lane position and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lane_idx   <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (xfer) begin
                lane_idx <= at_last_lane ? '0 : lane_idx + LANE_W'(1);
            end
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Directed self-checking bench for vector_lane_serializer (N=8, 16-bit lanes,
// depth 4); every expected value is computed from the vector tag and lane.
module tb_vector_lane_serializer;

    localparam int unsigned BW = 16;
    localparam int unsigned NL = 8;
    localparam int unsigned DP = 4;

    logic              clk;
    logic              rstn;
    logic [NL*BW-1:0]  in;
    logic              in_valid;
    logic              in_last;
    logic [BW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              overflow;
    logic [$clog2(DP):0] fifo_count;

    int checks;
    int failures;

    vector_lane_serializer #(
        .bitwidth (BW),
        .N        (NL),
        .DEPTH    (DP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Lane i of vector tag k carries {k, i+1}.
    function automatic logic [BW-1:0] lane_val(input int k, input int i);
        return BW'((k << 8) | (i + 1));
    endfunction

    function automatic logic [NL*BW-1:0] make_vec(input int k);
        logic [NL*BW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NL); i++) v[i*BW +: BW] = lane_val(k, i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input int k, input logic last);
        in       = make_vec(k);
        in_last  = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Reset with in_valid high, which must be ignored.
    task automatic do_reset();
        rstn     = 1'b0;
        in       = make_vec(15);
        in_last  = 1'b1;
        in_valid = 1'b1;
        step();
        rstn     = 1'b1;
        in_valid = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        step();
        check("rst_ignore_in", 32'(fifo_count), 32'd0);
    endtask

    task automatic drain_check(input string tag, input int k0, input int nvec, input int last_k);
        out_ready = 1'b1;
        for (int v = 0; v < nvec; v++) begin
            for (int i = 0; i < int'(NL); i++) begin
                check({tag, "_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_data"}, 32'(out_data), 32'(lane_val(k0 + v, i)));
                check({tag, "_last"}, 32'(out_last), 32'((i == int'(NL) - 1) && (k0 + v == last_k)));
                step();
            end
        end
        check({tag, "_empty_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int nxt;
        int k;
        int ln;
        bit pushing;
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        do_reset();

        // Single vector, one cycle latency, full-rate drain.
        out_ready = 1'b1;
        push_vec(0, 1'b1);
        check("single_count", 32'(fifo_count), 32'd1);
        drain_check("single", 0, 1, 0);

        // Backpressure at lane 3.
        push_vec(1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_pre", 32'(out_data), 32'(lane_val(1, i)));
            step();
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", 32'(out_data), 32'(lane_val(1, 3)));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        for (int i = 3; i < int'(NL); i++) begin
            check("bp_resume", 32'(out_data), 32'(lane_val(1, i)));
            check("bp_last", 32'(out_last), 32'(i == int'(NL) - 1));
            step();
        end
        check("bp_count", 32'(fifo_count), 32'd0);

        // Overflow: five back-to-back vectors into a stalled FIFO.
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) push_vec(v, v == 4);
        check("ovf_full_count", 32'(fifo_count), 32'd4);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        push_vec(5, 1'b1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        drain_check("ovf_drain", 1, 4, 4);
        check("ovf_sticky", 32'(overflow), 32'd1);

        do_reset();

        // Full FIFO with a pop on the same cycle still drops the input.
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) push_vec(v, v == 4);
        check("fp_count4", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < int'(NL) - 1; i++) begin
            check("fp_adv", 32'(out_data), 32'(lane_val(1, i)));
            step();
        end
        check("fp_lane7", 32'(out_data), 32'(lane_val(1, 7)));
        check("fp_lane7_last", 32'(out_last), 32'd0);
        push_vec(9, 1'b1);
        check("fp_count3", 32'(fifo_count), 32'd3);
        check("fp_ovf", 32'(overflow), 32'd1);
        drain_check("fp_drain", 2, 3, 4);

        do_reset();

        // Steady push/pop at depth 2 over ten vectors; in_last on every third.
        out_ready = 1'b0;
        push_vec(20, 1'b0);
        push_vec(21, 1'b0);
        check("wrap_count_pre", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
        nxt = 2;
        for (int e = 0; e < 10 * int'(NL); e++) begin
            k  = e / int'(NL);
            ln = e % int'(NL);
            check("wrap_data", 32'(out_data), 32'(lane_val(20 + k, ln)));
            check("wrap_last", 32'(out_last), 32'((ln == int'(NL) - 1) && (k % 3 == 2)));
            pushing = (ln == int'(NL) - 1) && (nxt < 10);
            if (pushing) begin
                in       = make_vec(20 + nxt);
                in_last  = (nxt % 3 == 2);
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            if (pushing) begin
                check("wrap_count_hold", 32'(fifo_count), 32'd2);
                nxt++;
            end
        end
        check("wrap_end_count", 32'(fifo_count), 32'd0);
        check("wrap_ovf", 32'(overflow), 32'd0);

        do_reset();

        // Reset mid-vector discards stored vectors and the lane position.
        out_ready = 1'b0;
        for (int v = 30; v <= 32; v++) push_vec(v, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("mid_lane4", 32'(out_data), 32'(lane_val(30, 4)));
        check("mid_count3", 32'(fifo_count), 32'd3);
        rstn     = 1'b0;
        in       = make_vec(33);
        in_last  = 1'b1;
        in_valid = 1'b1;
        step();
        rstn     = 1'b1;
        in_valid = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        step();
        check("mid_rst_ignore", 32'(fifo_count), 32'd0);
        push_vec(34, 1'b1);
        drain_check("mid_after", 34, 1, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_lane_serializer.md
VECTOR_LANE_SERIALIZER -- requirements
Module: vector_lane_serializer

Interface
REQ-001 Parameter bitwidth, default 16, SHALL set the width of one lane element.
REQ-002 Parameter N, default 8, SHALL set the lanes per input vector.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, SHALL set the vector FIFO depth.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  SHALL be the synchronous active-low reset, sampled on the rising clk edge.
REQ-006 in  input  N*bitwidth  SHALL carry the vector from the multiplier stage; lane i is in[i*bitwidth +: bitwidth].
REQ-007 in_valid  input  1  SHALL qualify in and in_last; there is no input ready.
REQ-008 in_last  input  1  SHALL mark the final vector of a packet.
REQ-009 out_data  output  bitwidth  SHALL carry one lane element.
REQ-010 out_valid  output  1  SHALL qualify out_data and out_last.
REQ-011 out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-012 out_last  output  1  SHALL mark the final element of a packet.
REQ-013 overflow  output  1  SHALL be a sticky flag for any dropped input vector.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  SHALL report the number of stored vectors.

Function
REQ-015 The block SHALL write {in_last, in} into the FIFO on a cycle with in_valid=1 and fifo_count<DEPTH.
REQ-016 On a cycle with in_valid=1 and fifo_count==DEPTH, the vector SHALL be dropped and overflow SHALL be set to 1, even if a pop occurs in the same cycle.
REQ-017 overflow SHALL remain 1 until reset.
REQ-018 out_valid SHALL equal (fifo_count != 0).
REQ-019 A lane counter lane_idx (0..N-1) SHALL select the head element; out_data SHALL equal head_vector[lane_idx*bitwidth +: bitwidth].
REQ-020 Lanes SHALL be emitted in order 0 first through N-1 last.
REQ-021 A transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-022 On a transfer with lane_idx<N-1, lane_idx SHALL increment.
REQ-023 On a transfer with lane_idx==N-1, lane_idx SHALL return to 0 and the head vector SHALL be popped.
REQ-024 out_last SHALL equal head_last AND (lane_idx==N-1) AND out_valid.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and lane_idx SHALL hold.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 FIFO storage SHALL be registered and read combinationally from the head pointer.
REQ-029 A vector written at cycle t into an empty FIFO SHALL appear on out_data/out_valid at cycle t+1.
REQ-030 Throughput SHALL be one element per cycle with out_ready held at 1, i.e. one vector per N cycles.

Reset
REQ-031 While rstn=0 at a clock edge, the block SHALL clear fifo_count, both pointers, lane_idx and overflow to 0.
REQ-032 out_valid and out_last SHALL read 0 in the cycle after reset is applied.
REQ-033 Reset mid-vector SHALL discard all stored vectors and the partial lane position.
REQ-034 in_valid SHALL be ignored in any cycle where rstn=0.

Verification
REQ-035 Single vector, lanes 0x0001..0x0008, in_last=1, out_ready=1 -> out_data is 0x0001..0x0008 over 8 consecutive cycles starting one cycle after input; out_last=1 only on 0x0008; fifo_count returns to 0.
REQ-036 Backpressure: out_ready=0 for 5 cycles at lane 3 -> out_data holds lane 3 value, lane_idx frozen; sequence resumes at lane 3 with no loss or duplication.
REQ-037 Overflow: 5 vectors on consecutive cycles with out_ready=0 -> fifo_count=4, fifth vector dropped, overflow=1; drained output is exactly vectors 1-4, 32 elements.
REQ-038 Full plus pop: fifo_count=4, lane_idx=7 transfer coincides with in_valid=1 -> input dropped, overflow=1, fifo_count=3.
REQ-039 Simultaneous push/pop at fifo_count=2 -> fifo_count stays 2; pointer wrap exercised over 10 vectors with in_last on every third vector -> out_last asserted on lane 7 of vectors 3, 6 and 9 only.
REQ-040 Reset asserted at lane 4 with fifo_count=3 -> the next cycle shows out_valid=0, fifo_count=0, overflow=0; a following vector emits starting from lane 0.
